// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for alu_op_sequencer: command codes, ALU op encodings, FSM states.
// ALU_OP_SEQUENCER_SLTU_EN makes command 7 (SLTU) legal; otherwise it is rejected.
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    CMD_AND   = 3'd0,
    CMD_OR    = 3'd1,
    CMD_ADD   = 3'd2,
    CMD_SUB   = 3'd3,
    CMD_SLT   = 3'd4,
    CMD_ADD64 = 3'd5,
    CMD_SUB64 = 3'd6,
    CMD_SLTU  = 3'd7
  } cmd_e;

  localparam logic [1:0] ALU_OP_AND = 2'b00;
  localparam logic [1:0] ALU_OP_OR  = 2'b01;
  localparam logic [1:0] ALU_OP_ADD = 2'b10;

`ifdef ALU_OP_SEQUENCER_SLTU_EN
  localparam bit SLTU_EN = 1'b1;
`else
  localparam bit SLTU_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC_LO,
    ST_EXEC_HI,
    ST_DONE
  } state_e;

  function automatic logic is_wide(cmd_e c);
    return (c == CMD_ADD64) || (c == CMD_SUB64);
  endfunction

  // Every command that needs a - b on its first pass.
  function automatic logic is_subtract(cmd_e c);
    return (c == CMD_SUB) || (c == CMD_SLT) || (c == CMD_SUB64) || (c == CMD_SLTU);
  endfunction

  function automatic logic is_legal(cmd_e c);
    return (c != CMD_SLTU) || SLTU_EN;
  endfunction

  function automatic logic [1:0] lo_pass_op(cmd_e c);
    case (c)
      CMD_AND: return ALU_OP_AND;
      CMD_OR:  return ALU_OP_OR;
      default: return ALU_OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for a 32-bit combinational ALU: runs one or two ALU passes
// per request and returns the result on a valid/ready channel. Optional: ALU_OP_SEQUENCER_SLTU_EN.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int CMD_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CMD_W-1:0] req_cmd,
  input  logic [31:0]      req_a_lo,
  input  logic [31:0]      req_b_lo,
  input  logic [31:0]      req_a_hi,
  input  logic [31:0]      req_b_hi,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_lo,
  output logic [31:0]      resp_hi,
  output logic             resp_zero,
  output logic             resp_carry,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  output logic [1:0]       alu_op,
  output logic             alu_binvert,
  output logic             alu_cin,
  input  logic [31:0]      alu_out,
  input  logic             alu_zero,
  input  logic             alu_cout
);

  state_e      state_q, state_d;
  cmd_e        cmd_q;
  cmd_e        req_cmd_e;
  logic [31:0] a_hi_q, b_hi_q;

  logic        slt_ovf;
  logic        slt_bit;
  logic [31:0] lo_res;
  logic        lo_zero;
  logic        lo_carry;

  assign req_cmd_e = cmd_e'(req_cmd);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = !reset;
        if (req_valid) state_d = is_legal(req_cmd_e) ? ST_EXEC_LO : ST_DONE;
      end
      ST_EXEC_LO: state_d = is_wide(cmd_q) ? ST_EXEC_HI : ST_DONE;
      ST_EXEC_HI: state_d = ST_DONE;
      ST_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // First-pass result shaping. alu_in1/alu_in2 still hold a and b (uninverted),
  // so the signed-overflow term can be read straight from them.
  always_comb begin
    slt_ovf  = (alu_in1[31] != alu_in2[31]) && (alu_out[31] != alu_in1[31]);
    slt_bit  = alu_out[31] ^ slt_ovf;
    lo_res   = alu_out;
    lo_zero  = alu_zero;
    lo_carry = alu_cout;
    case (cmd_q)
      CMD_AND, CMD_OR: lo_carry = 1'b0;
      CMD_SLT: begin
        lo_res  = {31'b0, slt_bit};
        lo_zero = ~slt_bit;
      end
`ifdef ALU_OP_SEQUENCER_SLTU_EN
      CMD_SLTU: begin
        lo_res  = {31'b0, ~alu_cout};
        lo_zero = alu_cout;
      end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: every register here is reset; there is no memory array that would be
  // left out of the reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q       <= CMD_AND;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_op      <= ALU_OP_AND;
      alu_binvert <= 1'b0;
      alu_cin     <= 1'b0;
      resp_lo     <= '0;
      resp_hi     <= '0;
      resp_zero   <= 1'b0;
      resp_carry  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_q  <= req_cmd_e;
            a_hi_q <= req_a_hi;
            b_hi_q <= req_b_hi;
            if (is_legal(req_cmd_e)) begin
              alu_in1     <= req_a_lo;
              alu_in2     <= req_b_lo;
              alu_op      <= lo_pass_op(req_cmd_e);
              alu_binvert <= is_subtract(req_cmd_e);
              alu_cin     <= is_subtract(req_cmd_e);
            end else begin
              // Illegal command: answer immediately with an all-zero result.
              resp_lo    <= '0;
              resp_hi    <= '0;
              resp_zero  <= 1'b1;
              resp_carry <= 1'b0;
            end
          end
        end
        ST_EXEC_LO: begin
          resp_lo    <= lo_res;
          resp_hi    <= '0;
          resp_zero  <= lo_zero;
          resp_carry <= lo_carry;
          if (is_wide(cmd_q)) begin
            // High pass chains the low Cout through Cin; binvert must stay 0
            // because the ALU would force Cin to 1, so SUB64 inverts B here.
            alu_in1     <= a_hi_q;
            alu_in2     <= (cmd_q == CMD_SUB64) ? ~b_hi_q : b_hi_q;
            alu_op      <= ALU_OP_ADD;
            alu_binvert <= 1'b0;
            alu_cin     <= alu_cout;
          end
        end
        ST_EXEC_HI: begin
          resp_hi    <= alu_out;
          resp_zero  <= resp_zero && alu_zero;
          resp_carry <= alu_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, directed vector table,
// randomized commands against a 64-bit arithmetic reference, backpressure and reset cases.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [31:0] req_a_lo, req_b_lo, req_a_hi, req_b_hi;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_lo, resp_hi;
  logic        resp_zero, resp_carry;
  logic [31:0] alu_in1, alu_in2;
  logic [1:0]  alu_op;
  logic        alu_binvert, alu_cin;
  logic [31:0] alu_out;
  logic        alu_zero, alu_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.CMD_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a_lo(req_a_lo), .req_b_lo(req_b_lo), .req_a_hi(req_a_hi), .req_b_hi(req_b_hi),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_lo(resp_lo), .resp_hi(resp_hi), .resp_zero(resp_zero), .resp_carry(resp_carry),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_binvert(alu_binvert), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_cout(alu_cout)
  );

  // Combinational ALU: Cin forced to 1 whenever binvert is set.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_in1} + {1'b0, (alu_binvert ? ~alu_in2 : alu_in2)}
            + {32'b0, (alu_binvert | alu_cin)};
    case (alu_op)
      2'b00:   alu_out = alu_in1 & alu_in2;
      2'b01:   alu_out = alu_in1 | alu_in2;
      default: alu_out = alu_sum[31:0];
    endcase
    alu_zero = (alu_out == 32'b0);
    alu_cout = alu_sum[32];
  end

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        carry;
    int          lat;
    logic [1:0]  op;
    logic        binv;
    logic        legal;
  } res_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [63:0] a;
    logic [63:0] b;
    res_t        exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operand values.
  function automatic res_t ref_model(input logic [2:0] cmd, input logic [63:0] a, input logic [63:0] b);
    res_t r;
    logic [32:0] s33;
    logic [64:0] s65;
    r.hi = '0; r.carry = 1'b0; r.lat = 2; r.legal = 1'b1;
    r.op = 2'b10; r.binv = 1'b0; r.lo = '0;
    case (cmd)
      3'd0: begin r.lo = a[31:0] & b[31:0]; r.op = 2'b00; end
      3'd1: begin r.lo = a[31:0] | b[31:0]; r.op = 2'b01; end
      3'd2: begin s33 = {1'b0, a[31:0]} + {1'b0, b[31:0]}; r.lo = s33[31:0]; r.carry = s33[32]; end
      3'd3: begin r.lo = a[31:0] - b[31:0]; r.carry = (a[31:0] >= b[31:0]); r.binv = 1'b1; end
      3'd4: begin
        r.lo = ($signed(a[31:0]) < $signed(b[31:0])) ? 32'd1 : 32'd0;
        r.carry = (a[31:0] >= b[31:0]); r.binv = 1'b1;
      end
      3'd5: begin
        s65 = {1'b0, a} + {1'b0, b};
        {r.hi, r.lo} = s65[63:0]; r.carry = s65[64]; r.lat = 3;
      end
      3'd6: begin {r.hi, r.lo} = a - b; r.carry = (a >= b); r.lat = 3; r.binv = 1'b1; end
      default: begin
`ifdef ALU_OP_SEQUENCER_SLTU_EN
        r.lo = (a[31:0] < b[31:0]) ? 32'd1 : 32'd0;
        r.carry = (a[31:0] >= b[31:0]); r.binv = 1'b1;
`else
        r.lat = 1; r.legal = 1'b0;
`endif
      end
    endcase
    r.zero = ({r.hi, r.lo} == 64'b0);
    return r;
  endfunction

  // Issue one command and wait for its response; leaves the channel idle if resp_ready=1.
  task automatic run_cmd(input logic [2:0] cmd, input logic [63:0] a, input logic [63:0] b,
                         output res_t o);
    int guard = 0;
    o.lo = '0; o.hi = '0; o.zero = 0; o.carry = 0; o.lat = 0; o.op = '0; o.binv = 0; o.legal = 1;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      check("req_ready_timeout", {63'b0, req_ready}, 64'd1);
      return;
    end
    req_valid = 1'b1; req_cmd = cmd;
    req_a_lo = a[31:0]; req_a_hi = a[63:32]; req_b_lo = b[31:0]; req_b_hi = b[63:32];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    o.op = alu_op; o.binv = alu_binvert; o.lat = 1;
    while (!resp_valid && o.lat < 20) begin @(negedge clk); o.lat++; end
    o.lo = resp_lo; o.hi = resp_hi; o.zero = resp_zero; o.carry = resp_carry;
    if (resp_ready) @(negedge clk);
  endtask

  task automatic compare(input string tag, input res_t o, input res_t e);
    check({tag, ".lat"},   64'(o.lat),  64'(e.lat));
    check({tag, ".lo"},    64'(o.lo),   64'(e.lo));
    check({tag, ".hi"},    64'(o.hi),   64'(e.hi));
    check({tag, ".zero"},  64'(o.zero), 64'(e.zero));
    check({tag, ".carry"}, 64'(o.carry), 64'(e.carry));
    if (e.legal) begin
      check({tag, ".alu_op"},  64'(o.op),   64'(e.op));
      check({tag, ".binvert"}, 64'(o.binv), 64'(e.binv));
    end
  endtask

  function automatic res_t mk(input logic [31:0] lo, input logic [31:0] hi, input logic z,
                              input logic c, input int lat, input logic [1:0] op, input logic binv,
                              input logic legal);
    res_t r;
    r.lo = lo; r.hi = hi; r.zero = z; r.carry = c; r.lat = lat; r.op = op; r.binv = binv;
    r.legal = legal;
    return r;
  endfunction

  vec_t vecs[10];
  res_t o, e;
  logic [63:0] ra, rb;
  logic [2:0]  rc;
  bit          seen;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_cmd = '0;
    req_a_lo = '0; req_b_lo = '0; req_a_hi = '0; req_b_hi = '0; resp_ready = 1'b1;

    // Hand-computed vectors.
    vecs[0] = '{3'd2, 64'd5, 64'd7,                  mk(32'd12, 0, 0, 0, 2, 2'b10, 0, 1)};
    vecs[1] = '{3'd3, 64'h1234, 64'h1234,            mk(32'd0, 0, 1, 1, 2, 2'b10, 1, 1)};
    vecs[2] = '{3'd4, 64'h8000_0000, 64'h1,          mk(32'd1, 0, 0, 1, 2, 2'b10, 1, 1)};
    vecs[3] = '{3'd4, 64'd5, 64'd3,                  mk(32'd0, 0, 1, 1, 2, 2'b10, 1, 1)};
    vecs[4] = '{3'd5, 64'h0000_0000_FFFF_FFFF, 64'h1, mk(32'd0, 32'd1, 0, 0, 3, 2'b10, 0, 1)};
    vecs[5] = '{3'd6, 64'h0000_0001_0000_0000, 64'h1, mk(32'hFFFF_FFFF, 0, 0, 1, 3, 2'b10, 1, 1)};
    vecs[6] = '{3'd0, 64'hF0F0_F0F0, 64'hFF00_FF00,  mk(32'hF000_F000, 0, 0, 0, 2, 2'b00, 0, 1)};
    vecs[7] = '{3'd1, 64'd0, 64'd0,                  mk(32'd0, 0, 1, 0, 2, 2'b01, 0, 1)};
`ifdef ALU_OP_SEQUENCER_SLTU_EN
    vecs[8] = '{3'd7, 64'd1, 64'd2,                  mk(32'd1, 0, 0, 0, 2, 2'b10, 1, 1)};
`else
    vecs[8] = '{3'd7, 64'd1, 64'd2,                  mk(32'd0, 0, 1, 0, 1, 2'b00, 0, 0)};
`endif
    vecs[9] = '{3'd2, 64'hFFFF_FFFF, 64'h1,          mk(32'd0, 0, 1, 1, 2, 2'b10, 0, 1)};

    // Reset with a simultaneous request: outputs zero, nothing accepted.
    req_valid = 1'b1; req_cmd = 3'd2; req_a_lo = 32'd1; req_b_lo = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_zero",
          {63'b0, |{req_ready, resp_valid, resp_lo, resp_hi, resp_zero, resp_carry,
                    alu_in1, alu_in2, alu_op, alu_binvert, alu_cin}}, 64'd0);
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {63'b0, req_ready}, 64'd1);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    check("no_resp_after_reset_req", {63'b0, seen}, 64'd0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].cmd, vecs[i].a, vecs[i].b, o);
      compare($sformatf("vec%0d", i), o, vecs[i].exp);
    end

    // Randomized commands against the reference model.
    for (int n = 0; n < 60; n++) begin
      rc = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: begin ra[31:0] = 32'h8000_0000; rb[31:0] = 32'($urandom_range(0, 3)); end
        2: ra[31:0] = 32'hFFFF_FFFF;
        default: ;
      endcase
      e = ref_model(rc, ra, rb);
      run_cmd(rc, ra, rb, o);
      compare($sformatf("rnd%0d_cmd%0d", n, rc), o, e);
    end

    // Backpressure: response held for 5 cycles with resp_ready low.
    resp_ready = 1'b0;
    e = ref_model(3'd3, 64'd100, 64'd200);
    run_cmd(3'd3, 64'd100, 64'd200, o);
    compare("bp_first", o, e);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d.valid", k), {63'b0, resp_valid}, 64'd1);
      check($sformatf("bp%0d.ready", k), {63'b0, req_ready}, 64'd0);
      check($sformatf("bp%0d.resp", k), {resp_hi, resp_lo}, {e.hi, e.lo});
      check($sformatf("bp%0d.flags", k), {62'b0, resp_zero, resp_carry}, {62'b0, e.zero, e.carry});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release.valid", {63'b0, resp_valid}, 64'd0);
    check("bp_release.ready", {63'b0, req_ready}, 64'd1);

    // Reset during EXEC_HI of a SUB64: in-flight command dropped.
    req_valid = 1'b1; req_cmd = 3'd6;
    req_a_lo = 32'h0; req_a_hi = 32'h1; req_b_lo = 32'h1; req_b_hi = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("sub64_hi.in2", 64'(alu_in2), 64'hFFFF_FFFF);
    check("sub64_hi.cin", {63'b0, alu_cin}, 64'd0);
    check("sub64_hi.binvert", {63'b0, alu_binvert}, 64'd0);
    check("sub64_hi.in1", 64'(alu_in1), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset_outputs_zero",
          {63'b0, |{req_ready, resp_valid, resp_lo, resp_hi, resp_zero, resp_carry,
                    alu_in1, alu_in2, alu_op, alu_binvert, alu_cin}}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    check("midop_reset_no_resp", {63'b0, seen}, 64'd0);
    check("midop_reset_ready", {63'b0, req_ready}, 64'd1);
    e = ref_model(3'd2, 64'd9, 64'd10);
    run_cmd(3'd2, 64'd9, 64'd10, o);
    compare("post_reset_add", o, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
